// File: rtl/imem_arbiter.sv
// Shares one single-port sync-read instruction memory between fetch (IF) and loader (LD).
// Grants are combinational; read data returns one cycle after a read grant.
// A refused requester holds its request; a loader starvation counter and a lock mode bound its wait.
module imem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_if_req,
    input  logic [ADDR_WIDTH-1:0] i_if_addr,
    output logic                  o_if_gnt,
    output logic                  o_if_rvalid,
    output logic [DATA_WIDTH-1:0] o_if_rdata,
    input  logic                  i_ld_req,
    input  logic                  i_ld_we,
    input  logic                  i_ld_lock,
    input  logic [ADDR_WIDTH-1:0] i_ld_addr,
    input  logic [DATA_WIDTH-1:0] i_ld_wdata,
    output logic                  o_ld_gnt,
    output logic                  o_ld_rvalid,
    output logic [DATA_WIDTH-1:0] o_ld_rdata,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    localparam int WCW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [WCW-1:0] wait_cnt_q;
    logic [WCW-1:0] wait_cnt_d;
    logic           if_rvalid_q;
    logic           ld_rvalid_q;
    logic           starved;
    logic           if_gnt;
    logic           ld_gnt;

    // With MAX_WAIT = 0 the counter never leaves 0, so the loader is always starved.
    assign starved = (wait_cnt_q == WAIT_LIMIT);

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            state_q     <= ST_ARB;
            wait_cnt_q  <= '0;
            if_rvalid_q <= 1'b0;
            ld_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            if_rvalid_q <= if_gnt;
            ld_rvalid_q <= ld_gnt & ~i_ld_we;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB:    if (ld_gnt && i_ld_lock) state_d = ST_LOCKED;
            ST_LOCKED: if (!i_ld_lock)          state_d = ST_ARB;
            default:                            state_d = ST_ARB;
        endcase
    end

    // Grants are forced low while reset is asserted so every output reads 0 in reset.
    always_comb begin
        if_gnt = 1'b0;
        ld_gnt = 1'b0;
        if (i_arst) begin
            case (state_q)
                ST_ARB: begin
                    if_gnt = i_if_req & ~(i_ld_req & starved);
                    ld_gnt = i_ld_req & (~i_if_req | starved);
                end
                ST_LOCKED: ld_gnt = i_ld_req;
                default: begin
                    if_gnt = 1'b0;
                    ld_gnt = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == ST_LOCKED || !i_ld_req || ld_gnt) begin
            wait_cnt_d = '0;
        end else if (!starved) begin
            wait_cnt_d = wait_cnt_q + WCW'(1);
        end
    end

    assign o_if_gnt    = if_gnt;
    assign o_ld_gnt    = ld_gnt;
    assign o_mem_en    = if_gnt | ld_gnt;
    assign o_mem_we    = ld_gnt & i_ld_we;
    assign o_mem_addr  = ld_gnt ? i_ld_addr : (if_gnt ? i_if_addr : '0);
    assign o_mem_wdata = ld_gnt ? i_ld_wdata : '0;

    assign o_if_rvalid = if_rvalid_q;
    assign o_ld_rvalid = ld_rvalid_q;
    assign o_if_rdata  = if_rvalid_q ? i_mem_rdata : '0;
    assign o_ld_rdata  = ld_rvalid_q ? i_mem_rdata : '0;

    a_one_grant: assert property (@(posedge i_clk) disable iff (!i_arst) !(if_gnt && ld_gnt));

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed-vector bench for imem_arbiter with a small synchronous-read memory model.
module tb_imem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_arst;
    logic        i_if_req;
    logic [9:0]  i_if_addr;
    logic        o_if_gnt;
    logic        o_if_rvalid;
    logic [31:0] o_if_rdata;
    logic        i_ld_req;
    logic        i_ld_we;
    logic        i_ld_lock;
    logic [9:0]  i_ld_addr;
    logic [31:0] i_ld_wdata;
    logic        o_ld_gnt;
    logic        o_ld_rvalid;
    logic [31:0] o_ld_rdata;
    logic        o_mem_en;
    logic        o_mem_we;
    logic [9:0]  o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata = '0;

    imem_arbiter dut (
        .i_clk       (i_clk),
        .i_arst      (i_arst),
        .i_if_req    (i_if_req),
        .i_if_addr   (i_if_addr),
        .o_if_gnt    (o_if_gnt),
        .o_if_rvalid (o_if_rvalid),
        .o_if_rdata  (o_if_rdata),
        .i_ld_req    (i_ld_req),
        .i_ld_we     (i_ld_we),
        .i_ld_lock   (i_ld_lock),
        .i_ld_addr   (i_ld_addr),
        .i_ld_wdata  (i_ld_wdata),
        .o_ld_gnt    (o_ld_gnt),
        .o_ld_rvalid (o_ld_rvalid),
        .o_ld_rdata  (o_ld_rdata),
        .o_mem_en    (o_mem_en),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    // Memory contents: mem[i] = (i << 7) | 0x13, so mem[0..2] = 0x13, 0x93, 0x113.
    logic [31:0] mem [1024];
    initial for (int i = 0; i < 1024; i++) mem[i] = (32'(i) << 7) | 32'h13;

    always @(posedge i_clk) begin
        if (o_mem_en) begin
            if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
            else          i_mem_rdata     <= mem[o_mem_addr];
        end
    end

    typedef struct packed {
        logic        if_req;
        logic [9:0]  if_addr;
        logic        ld_req;
        logic        ld_we;
        logic        ld_lock;
        logic [9:0]  ld_addr;
        logic [31:0] ld_wdata;
    } in_t;

    typedef struct packed {
        logic        if_gnt;
        logic        ld_gnt;
        logic        mem_en;
        logic        mem_we;
        logic [9:0]  mem_addr;
        logic [31:0] mem_wdata;
        logic        if_rv;
        logic [31:0] if_rd;
        logic        ld_rv;
        logic [31:0] ld_rd;
    } out_t;

    typedef struct {
        string name;
        in_t   in;
        out_t  exp;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic in_t mi(logic ifr, logic [9:0] ifa, logic ldr, logic we, logic lk,
                               logic [9:0] lda, logic [31:0] wd);
        in_t r;
        r = '{ifr, ifa, ldr, we, lk, lda, wd};
        return r;
    endfunction

    function automatic out_t mo(logic ig, logic lg, logic en, logic we, logic [9:0] a,
                                logic [31:0] wd, logic irv, logic [31:0] ird,
                                logic lrv, logic [31:0] lrd);
        out_t r;
        r = '{ig, lg, en, we, a, wd, irv, ird, lrv, lrd};
        return r;
    endfunction

    task automatic add(string n, in_t i, out_t o);
        vec_t v;
        v.name = n;
        v.in   = i;
        v.exp  = o;
        vq.push_back(v);
    endtask

    task automatic drive(in_t i);
        i_if_req   = i.if_req;
        i_if_addr  = i.if_addr;
        i_ld_req   = i.ld_req;
        i_ld_we    = i.ld_we;
        i_ld_lock  = i.ld_lock;
        i_ld_addr  = i.ld_addr;
        i_ld_wdata = i.ld_wdata;
    endtask

    task automatic check(string n, out_t exp);
        out_t got;
        got = '{o_if_gnt, o_ld_gnt, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
                o_if_rvalid, o_if_rdata, o_ld_rvalid, o_ld_rdata};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t  idle;
        out_t zero;
        idle = mi(0, 0, 0, 0, 0, 0, 0);
        zero = mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Fetch-only stream, data returns the following cycle.
        add("idle",     idle,                     zero);
        add("if0",      mi(1, 0, 0, 0, 0, 0, 0),  mo(1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        add("if1",      mi(1, 1, 0, 0, 0, 0, 0),  mo(1, 0, 1, 0, 1, 0, 1, 32'h13, 0, 0));
        add("if2",      mi(1, 2, 0, 0, 0, 0, 0),  mo(1, 0, 1, 0, 2, 0, 1, 32'h93, 0, 0));
        add("if_drain", idle,                     mo(0, 0, 0, 0, 0, 0, 1, 32'h113, 0, 0));
        // Loader write (no rvalid), then read it back.
        add("ld_wr",    mi(0, 0, 1, 1, 0, 10'h3FF, 32'hDEADBEEF),
                        mo(0, 1, 1, 1, 10'h3FF, 32'hDEADBEEF, 0, 0, 0, 0));
        add("ld_rd",    mi(0, 0, 1, 0, 0, 10'h3FF, 0), mo(0, 1, 1, 0, 10'h3FF, 0, 0, 0, 0, 0));
        add("ld_rd_dat", idle, mo(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF));
        // Interleaved reads: each response goes to its own port.
        add("il_if5",   mi(1, 5, 0, 0, 0, 0, 0),  mo(1, 0, 1, 0, 5, 0, 0, 0, 0, 0));
        add("il_ld9",   mi(0, 0, 1, 0, 0, 9, 0),  mo(0, 1, 1, 0, 9, 0, 1, 32'h293, 0, 0));
        add("il_done",  idle,                     mo(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h493));
        // Continuous contention: four fetch grants then one loader grant, repeating.
        add("ct1", mi(1, 1, 1, 0, 0, 2, 0), mo(1, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        for (int k = 2; k <= 4; k++)
            add($sformatf("ct%0d", k), mi(1, 1, 1, 0, 0, 2, 0), mo(1, 0, 1, 0, 1, 0, 1, 32'h93, 0, 0));
        add("ct5",  mi(1, 1, 1, 0, 0, 2, 0), mo(0, 1, 1, 0, 2, 0, 1, 32'h93, 0, 0));
        add("ct6",  mi(1, 1, 1, 0, 0, 2, 0), mo(1, 0, 1, 0, 1, 0, 0, 0, 1, 32'h113));
        for (int k = 7; k <= 9; k++)
            add($sformatf("ct%0d", k), mi(1, 1, 1, 0, 0, 2, 0), mo(1, 0, 1, 0, 1, 0, 1, 32'h93, 0, 0));
        add("ct10", mi(1, 1, 1, 0, 0, 2, 0), mo(0, 1, 1, 0, 2, 0, 1, 32'h93, 0, 0));
        add("ct11", idle, mo(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h113));
        // Lock: fetch is shut out for the locked burst and the lock-drop cycle.
        add("lk0", mi(0, 0, 1, 1, 1, 10'h10, 32'hA0), mo(0, 1, 1, 1, 10'h10, 32'hA0, 0, 0, 0, 0));
        for (int k = 0; k < 8; k++)
            add($sformatf("lk_wr%0d", k), mi(1, 3, 1, 1, 1, 10'(10'h11 + k), 32'hB0 + 32'(k)),
                mo(0, 1, 1, 1, 10'(10'h11 + k), 32'hB0 + 32'(k), 0, 0, 0, 0));
        add("lk_drop", mi(1, 3, 1, 1, 0, 10'h20, 32'hC0), mo(0, 1, 1, 1, 10'h20, 32'hC0, 0, 0, 0, 0));
        add("lk_after", mi(1, 3, 0, 0, 0, 0, 0), mo(1, 0, 1, 0, 3, 0, 0, 0, 0, 0));
        add("lk_if_dat", idle, mo(0, 0, 0, 0, 0, 0, 1, 32'h193, 0, 0));
        add("lk_rb", mi(0, 0, 1, 0, 0, 10'h11, 0), mo(0, 1, 1, 0, 10'h11, 0, 0, 0, 0, 0));
        add("lk_rb_dat", idle, mo(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hB0));
        // Starvation count clears when the loader drops its request for a cycle.
        add("sv1", mi(1, 1, 1, 0, 0, 2, 0), mo(1, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        add("sv2", mi(1, 1, 1, 0, 0, 2, 0), mo(1, 0, 1, 0, 1, 0, 1, 32'h93, 0, 0));
        add("sv3", mi(1, 1, 0, 0, 0, 0, 0), mo(1, 0, 1, 0, 1, 0, 1, 32'h93, 0, 0));
        for (int k = 4; k <= 7; k++)
            add($sformatf("sv%0d", k), mi(1, 1, 1, 0, 0, 2, 0), mo(1, 0, 1, 0, 1, 0, 1, 32'h93, 0, 0));
        add("sv8", mi(1, 1, 1, 0, 0, 2, 0), mo(0, 1, 1, 0, 2, 0, 1, 32'h93, 0, 0));
        add("sv9", idle, mo(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h113));

        // Reset with active requests: every output must be 0.
        i_arst = 1'b0;
        drive(mi(1, 7, 1, 1, 1, 10'h55, 32'h12345678));
        #1 check("rst_hold", zero);
        repeat (3) @(posedge i_clk);
        #1 check("rst_hold2", zero);
        @(negedge i_clk);
        drive(idle);
        i_arst = 1'b1;

        foreach (vq[k]) begin
            @(negedge i_clk);
            drive(vq[k].in);
            #1 check(vq[k].name, vq[k].exp);
        end

        // Reset half a cycle after a read grant: the pending response is dropped.
        @(negedge i_clk);
        drive(mi(1, 4, 0, 0, 0, 0, 0));
        #1 check("rr_gnt", mo(1, 0, 1, 0, 4, 0, 0, 0, 0, 0));
        @(negedge i_clk);
        i_arst = 1'b0;
        #1 check("rr_in_reset", zero);
        @(negedge i_clk);
        drive(idle);
        #1 check("rr_in_reset2", zero);
        @(negedge i_clk);
        i_arst = 1'b1;
        #1 check("rr_release", zero);
        @(negedge i_clk);
        #1 check("rr_release2", zero);
        // Arbiter comes back in ARB with a cleared count: fetch wins contention.
        @(negedge i_clk);
        drive(mi(1, 0, 1, 0, 0, 1, 0));
        #1 check("rr_arb", mo(1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        @(negedge i_clk);
        drive(idle);
        #1 check("rr_arb_dat", mo(0, 0, 0, 0, 0, 0, 1, 32'h13, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
Shares one single-port, synchronous-read instruction memory (1-cycle read latency) between two requesters: the core fetch unit (port IF) and the program loader/debug port (port LD, read/write). Fetch has default priority. A starvation counter bounds loader wait. A lock mode gives the loader exclusive access for bulk program loads. Sits between the fetch stage/loader and the instruction memory macro.

Parameters:
DATA_WIDTH, 32, memory word width
ADDR_WIDTH, 10, word address width
MAX_WAIT, 4, max consecutive contended cycles the loader may be refused before it wins (0 = loader wins every contended cycle)

Ports:
i_clk  input  1  clock, all state on rising edge
i_arst  input  1  asynchronous, active-low reset
i_if_req  input  1  fetch read request
i_if_addr  input  ADDR_WIDTH  fetch word address
o_if_gnt  output  1  fetch request accepted this cycle
o_if_rvalid  output  1  fetch read data valid
o_if_rdata  output  DATA_WIDTH  fetch read data
i_ld_req  input  1  loader request
i_ld_we  input  1  loader write (1) / read (0)
i_ld_lock  input  1  loader requests exclusive access
i_ld_addr  input  ADDR_WIDTH  loader word address
i_ld_wdata  input  DATA_WIDTH  loader write data
o_ld_gnt  output  1  loader request accepted this cycle
o_ld_rvalid  output  1  loader read data valid
o_ld_rdata  output  DATA_WIDTH  loader read data
o_mem_en  output  1  memory access enable
o_mem_we  output  1  memory write enable
o_mem_addr  output  ADDR_WIDTH  memory address
o_mem_wdata  output  DATA_WIDTH  memory write data
i_mem_rdata  input  DATA_WIDTH  memory read data, valid 1 cycle after read access

Behaviour:
- Reset (i_arst low, async): state ARB, wait_cnt 0, both rvalid 0. Pending read responses are discarded, never delivered after reset release. All outputs 0 during reset.
- Grants are combinational from requests and registered state. At most one gnt per cycle. o_mem_en = o_if_gnt | o_ld_gnt.
- Memory outputs are muxed from the granted port. o_mem_we = o_ld_gnt & i_ld_we. Address/wdata are 0 when no grant.
- Requesters hold req/addr/wdata/we stable until gnt. The arbiter does not register requests.
- Read latency: rvalid of the granted port asserts exactly 1 cycle after a read grant (registered). o_*_rdata = i_mem_rdata while that port's rvalid = 1, else 0.
- Loader writes get no rvalid; gnt is the write acknowledge.
- Back-to-back grants are allowed every cycle on either port. A pipelined read on a new grant coexists with rvalid of the previous one.
- States:
  - ARB: normal arbitration.
  - LOCKED: only the loader can be granted; o_if_gnt = 0.
- Arbitration in ARB:
  - Only one requester: that requester is granted.
  - Both requesting: loader wins if wait_cnt == MAX_WAIT, else fetch wins.
- wait_cnt (width clog2(MAX_WAIT+1), min 1):
  - Increments (saturating at MAX_WAIT) each cycle i_ld_req = 1 and o_ld_gnt = 0.
  - Clears when o_ld_gnt = 1 or i_ld_req = 0.
- Transitions:
  - ARB -> LOCKED when o_ld_gnt & i_ld_lock.
  - LOCKED -> ARB on the next edge after a cycle with i_ld_lock = 0. In that cycle the arbiter still behaves as LOCKED: the loader may be granted, fetch may not.
  - wait_cnt held at 0 in LOCKED.
- Simultaneous: a read grant to one port in the cycle after a read grant to the other port gives rvalid to each port in its own respective next cycle. Responses are never misrouted.

Test Plan:
- Reset: drive i_arst low mid-read (if read grant at cycle N, reset at N+0.5) -> o_if_rvalid stays 0 after release; all outputs 0 during reset.
- Fetch only: i_if_req = 1, addresses 0,1,2 on consecutive cycles, memory returns 0x13,0x93,0x113 -> gnt each cycle, o_if_rvalid with matching data at cycles +1, +2, +3.
- Contention, MAX_WAIT = 4: both request continuously -> fetch granted 4 cycles, loader granted on 5th, pattern repeats; o_mem_addr follows the granted port.
- Loader write: i_ld_req = 1, i_ld_we = 1, addr 0x3FF, wdata 0xDEADBEEF, no fetch -> o_ld_gnt = 1, o_mem_we = 1, o_mem_addr = 0x3FF, o_mem_wdata = 0xDEADBEEF, no o_ld_rvalid.
- Lock: loader granted with i_ld_lock = 1, then 8 writes while fetch requests -> o_if_gnt = 0 throughout. Drop lock -> fetch granted on the cycle after the lock-low cycle.
- Interleaved reads: IF read addr 5 at cycle N, LD read addr 9 at N+1 -> o_if_rvalid at N+1 with mem[5], o_ld_rvalid at N+2 with mem[9].
